apb_master_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one APB3 master port among NREQ independent requesters. Each requester issues single read or write commands over a hold-until-done handshake. The block runs the APB SETUP/ACCESS phases and decodes the 16-slot PSEL from the address. It applies a PREADY timeout and returns read data and error status to the granted requester. It sits between testbench or control agents and the APB slave fabric, in place of a single fixed bus master.

---
 rtl/apb_master_arbiter.sv | 151 +++++++++++++++
 tb/tb_apb_master_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB3 master port among NREQ requesters,
// sequencing SETUP/ACCESS, decoding PSEL from PADDR[27:24] and bounding PREADY waits.
module apb_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0]      REQ_WRITE,
  input  logic [32*NREQ-1:0]   REQ_ADDR,
  input  logic [32*NREQ-1:0]   REQ_WDATA,
  output logic [NREQ-1:0]      DONE,
  output logic [31:0]          RDATA,
  output logic                 RESP_ERR,
  output logic [2:0]           GRANT_ID,
  output logic                 BUSY,
  output logic [31:0]          PADDR,
  output logic [15:0]          PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  localparam int TW    = $clog2(TIMEOUT + 2);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state, state_d;
  logic [2:0]        ptr;
  logic [TW-1:0]     tcnt;
  logic [NREQ-1:0]   eligible;
  logic              found;
  logic [2:0]        gidx;
  logic [31:0]       gaddr, gwdata;
  logic              gwrite;
  logic [NREQ-1:0]   done_vec;
  logic [2:0]        ptr_next;
  logic              complete, timed_out;

  // Round-robin pick: lowest eligible index at/after ptr, else lowest overall (wrap).
  always_comb begin
    eligible = REQ & ~DONE;
    found    = 1'b0;
    gidx     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found = 1'b1;
        gidx  = 3'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (eligible[i] && (3'(i) >= ptr)) gidx = 3'(i);
    end
    gaddr  = '0;
    gwdata = '0;
    gwrite = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == gidx) begin
        gaddr  = REQ_ADDR[32*i +: 32];
        gwdata = REQ_WDATA[32*i +: 32];
        gwrite = REQ_WRITE[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) done_vec[i] = (3'(i) == GRANT_ID);
    ptr_next = (GRANT_ID == 3'(NREQ - 1)) ? 3'd0 : GRANT_ID + 3'd1;
  end

  always_comb begin
    state_d   = state;
    complete  = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE:   if (found) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          complete = 1'b1;
        end else if (TO_EN && (tcnt == TW'(TIMEOUT))) begin
          complete  = 1'b1;
          timed_out = 1'b1;
        end
        if (complete) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_d;
  end

  // Every output is registered; reset clears them all, including mid-transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ptr      <= '0;
      tcnt     <= '0;
      DONE     <= '0;
      RDATA    <= '0;
      RESP_ERR <= 1'b0;
      GRANT_ID <= '0;
      BUSY     <= 1'b0;
      PADDR    <= '0;
      PSEL     <= '0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PWDATA   <= '0;
    end else begin
      DONE <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            PADDR    <= gaddr;
            PWDATA   <= gwdata;
            PWRITE   <= gwrite;
            GRANT_ID <= gidx;
            PSEL     <= 16'h0001 << gaddr[27:24];
            BUSY     <= 1'b1;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          tcnt    <= '0;
        end
        ACCESS: begin
          if (complete) begin
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= done_vec;
            RDATA    <= (timed_out || PWRITE) ? 32'd0 : PRDATA;
            RESP_ERR <= timed_out | PSLVERR;
            ptr      <= ptr_next;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios plus randomized
// rounds checked against a transaction-level round-robin model and APB slave model.
module tb_apb_master_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic                PCLK = 1'b0;
  logic                PRESET;
  logic [NREQ-1:0]     REQ, REQ_WRITE;
  logic [32*NREQ-1:0]  REQ_ADDR, REQ_WDATA;
  logic [NREQ-1:0]     DONE;
  logic [31:0]         RDATA;
  logic                RESP_ERR;
  logic [2:0]          GRANT_ID;
  logic                BUSY;
  logic [31:0]         PADDR;
  logic [15:0]         PSEL;
  logic                PENABLE, PWRITE;
  logic [31:0]         PWDATA, PRDATA;
  logic                PREADY, PSLVERR;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Slave behaviour knobs: explicit mode, or address-derived when s_auto is set.
  bit          s_auto     = 1'b0;
  bit          s_ready_en = 1'b1;
  bit          s_err      = 1'b0;
  int          s_waits    = 0;
  logic [31:0] s_rdata    = 32'd0;

  always #5 PCLK = ~PCLK;

  apb_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .DONE(DONE), .RDATA(RDATA),
    .RESP_ERR(RESP_ERR), .GRANT_ID(GRANT_ID), .BUSY(BUSY), .PADDR(PADDR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial begin
    int wcnt;
    int w;
    wcnt = 0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'd0;
    forever begin
      @(posedge PCLK); #1;
      if (PSEL != 16'd0 && PENABLE) begin
        w = s_auto ? int'(PADDR[1:0]) : s_waits;
        if (!s_ready_en)   PREADY = 1'b0;
        else if (wcnt < w) begin PREADY = 1'b0; wcnt++; end
        else               PREADY = 1'b1;
        PRDATA  = s_auto ? (PADDR ^ 32'h5A5A_A5A5) : s_rdata;
        PSLVERR = s_auto ? (PADDR[3:2] == 2'b11) : s_err;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom; wcnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge PCLK); #1;
    cyc++;
  endtask

  task automatic set_cmd(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
    REQ_WRITE[i] = wr;
    REQ_ADDR[32*i +: 32]  = a;
    REQ_WDATA[32*i +: 32] = d;
  endtask

  task automatic do_reset();
    PRESET = 1'b1; REQ = '0;
    step();
    PRESET = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      step();
      if (DONE !== '0) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1; REQ = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    step(); step();
    checks++;
    if ({DONE, RDATA, RESP_ERR, GRANT_ID, BUSY, PADDR, PSEL, PENABLE, PWRITE, PWDATA} !== '0)
      $display("FAIL reset_outputs: DONE=%b RDATA=%h ERR=%b GID=%0d BUSY=%b PADDR=%h PSEL=%h PEN=%b PWR=%b PWDATA=%h, required all 0",
               DONE, RDATA, RESP_ERR, GRANT_ID, BUSY, PADDR, PSEL, PENABLE, PWRITE, PWDATA);
    else passes++;
    PRESET = 1'b0;
    step(); step();
    checks++;
    if (BUSY !== 1'b0 || PSEL !== 16'd0)
      $display("FAIL idle_no_req: BUSY=%b PSEL=%h, required 0/0000", BUSY, PSEL);
    else passes++;
  endtask

  task automatic test_single_write();
    s_auto = 0; s_ready_en = 1; s_waits = 0; s_err = 0;
    set_cmd(1, 1'b1, 32'h0300_0010, 32'hDEAD_BEEF);
    REQ = 4'b0010;
    step();
    checks++;
    if (PSEL !== 16'h0008 || PENABLE !== 1'b0 || PWRITE !== 1'b1 || PWDATA !== 32'hDEAD_BEEF ||
        PADDR !== 32'h0300_0010 || GRANT_ID !== 3'd1 || BUSY !== 1'b1)
      $display("FAIL wr_setup: PSEL=%h PEN=%b PWR=%b PWDATA=%h PADDR=%h GID=%0d BUSY=%b, required 0008/0/1/deadbeef/03000010/1/1",
               PSEL, PENABLE, PWRITE, PWDATA, PADDR, GRANT_ID, BUSY);
    else passes++;
    step();
    checks++;
    if (PENABLE !== 1'b1 || PSEL !== 16'h0008 || DONE !== 4'b0000)
      $display("FAIL wr_access: PEN=%b PSEL=%h DONE=%b, required 1/0008/0000", PENABLE, PSEL, DONE);
    else passes++;
    step();
    checks++;
    if (DONE !== 4'b0010 || RESP_ERR !== 1'b0 || RDATA !== 32'd0 || PSEL !== 16'd0 || PENABLE !== 1'b0 || BUSY !== 1'b0)
      $display("FAIL wr_done: DONE=%b ERR=%b RDATA=%h PSEL=%h PEN=%b BUSY=%b, required 0010/0/0/0/0/0",
               DONE, RESP_ERR, RDATA, PSEL, PENABLE, BUSY);
    else passes++;
    REQ = '0;
    step();
    checks++;
    if (DONE !== 4'b0000) $display("FAIL wr_done_pulse: DONE=%b, required 0000", DONE);
    else passes++;
  endtask

  task automatic test_read_waits();
    int lat;
    s_waits = 3; s_rdata = 32'h1234_5678;
    set_cmd(0, 1'b0, 32'h0A00_0004, $urandom);
    REQ = 4'b0001;
    step();
    checks++;
    if (PSEL !== 16'h0400 || GRANT_ID !== 3'd0 || PWRITE !== 1'b0)
      $display("FAIL rd_setup: PSEL=%h GID=%0d PWR=%b, required 0400/0/0", PSEL, GRANT_ID, PWRITE);
    else passes++;
    wait_done(20, lat);
    checks++;
    if (lat !== 5) $display("FAIL rd_latency: DONE after %0d cycles from SETUP, required 5", lat);
    else passes++;
    checks++;
    if (DONE !== 4'b0001 || RDATA !== 32'h1234_5678 || RESP_ERR !== 1'b0)
      $display("FAIL rd_done: DONE=%b RDATA=%h ERR=%b, required 0001/12345678/0", DONE, RDATA, RESP_ERR);
    else passes++;
    REQ = '0; s_waits = 0;
    step();
  endtask

  task automatic test_error();
    int lat;
    s_err = 1; s_rdata = 32'hCAFE_0001;
    set_cmd(2, 1'b0, 32'h0500_0000, 32'd0);
    REQ = 4'b0100;
    wait_done(10, lat);
    checks++;
    if (lat !== 3 || DONE !== 4'b0100 || RESP_ERR !== 1'b1 || RDATA !== 32'hCAFE_0001)
      $display("FAIL slverr: lat=%0d DONE=%b ERR=%b RDATA=%h, required 3/0100/1/cafe0001", lat, DONE, RESP_ERR, RDATA);
    else passes++;
    REQ = '0; s_err = 0;
    step();
  endtask

  task automatic test_timeout();
    int lat;
    s_ready_en = 0; s_rdata = 32'hFFFF_FFFF;
    set_cmd(3, 1'b0, 32'h0F00_0020, 32'd0);
    REQ = 4'b1000;
    step(); step();
    checks++;
    if (PENABLE !== 1'b1 || PSEL !== 16'h8000)
      $display("FAIL to_access: PEN=%b PSEL=%h, required 1/8000", PENABLE, PSEL);
    else passes++;
    wait_done(20, lat);
    checks++;
    if (lat !== TIMEOUT + 1) $display("FAIL to_latency: DONE %0d cycles after ACCESS entry, required %0d", lat, TIMEOUT + 1);
    else passes++;
    checks++;
    if (DONE !== 4'b1000 || RESP_ERR !== 1'b1 || RDATA !== 32'd0 || PSEL !== 16'd0 || PENABLE !== 1'b0 || BUSY !== 1'b0)
      $display("FAIL to_done: DONE=%b ERR=%b RDATA=%h PSEL=%h PEN=%b BUSY=%b, required 1000/1/0/0/0/0",
               DONE, RESP_ERR, RDATA, PSEL, PENABLE, BUSY);
    else passes++;
    REQ = '0; s_ready_en = 1;
    step();
  endtask

  task automatic test_midchange();
    int lat;
    s_waits = 2;
    set_cmd(1, 1'b1, 32'h0200_0040, 32'h1111_2222);
    REQ = 4'b0010;
    step(); step();
    REQ = '0;
    set_cmd(1, 1'b0, 32'h0700_0000, 32'h3333_4444);
    step();
    checks++;
    if (PADDR !== 32'h0200_0040 || PWDATA !== 32'h1111_2222 || PWRITE !== 1'b1 || PSEL !== 16'h0004)
      $display("FAIL mid_latched: PADDR=%h PWDATA=%h PWR=%b PSEL=%h, required 02000040/11112222/1/0004",
               PADDR, PWDATA, PWRITE, PSEL);
    else passes++;
    wait_done(10, lat);
    checks++;
    if (lat !== 2 || DONE !== 4'b0010)
      $display("FAIL mid_done: lat=%0d DONE=%b, required 2/0010", lat, DONE);
    else passes++;
    s_waits = 0;
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    do_reset();
    set_cmd(2, 1'b1, 32'h0400_0000, 32'h5555_AAAA);
    REQ = 4'b0100;
    wait_done(10, lat);
    checks++;
    if (DONE !== 4'b0100) $display("FAIL rst_pre_done: DONE=%b, required 0100", DONE);
    else passes++;
    REQ = '0;
    step();
    s_ready_en = 0;
    set_cmd(3, 1'b1, 32'h0900_0008, 32'h0000_ABCD);
    REQ = 4'b1000;
    step(); step(); step();
    checks++;
    if (PENABLE !== 1'b1 || PADDR !== 32'h0900_0008)
      $display("FAIL rst_in_access: PEN=%b PADDR=%h, required 1/09000008", PENABLE, PADDR);
    else passes++;
    PRESET = 1'b1;
    step();
    checks++;
    if ({DONE, RDATA, RESP_ERR, GRANT_ID, BUSY, PADDR, PSEL, PENABLE, PWRITE, PWDATA} !== '0)
      $display("FAIL rst_mid_outputs: DONE=%b RDATA=%h ERR=%b GID=%0d BUSY=%b PADDR=%h PSEL=%h PEN=%b PWR=%b PWDATA=%h, required all 0",
               DONE, RDATA, RESP_ERR, GRANT_ID, BUSY, PADDR, PSEL, PENABLE, PWRITE, PWDATA);
    else passes++;
    PRESET = 1'b0; s_ready_en = 1; s_rdata = 32'h0BAD_F00D;
    set_cmd(2, 1'b0, 32'h0100_0000, 32'd0);
    REQ = 4'b1100;
    step();
    checks++;
    if (GRANT_ID !== 3'd2 || PSEL !== 16'h0002 || DONE !== 4'b0000)
      $display("FAIL rst_ptr_grant: GID=%0d PSEL=%h DONE=%b, required 2/0002/0000", GRANT_ID, PSEL, DONE);
    else passes++;
    wait_done(10, lat);
    checks++;
    if (lat !== 2 || DONE !== 4'b0100 || RDATA !== 32'h0BAD_F00D)
      $display("FAIL rst_post_done: lat=%0d DONE=%b RDATA=%h, required 2/0100/0badf00d", lat, DONE, RDATA);
    else passes++;
    REQ = '0;
    step();
  endtask

  task automatic test_round_robin();
    int order[$];
    int when[$];
    int done_at[NREQ];
    int idx;
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    s_waits = 0;
    for (int i = 0; i < NREQ; i++) begin
      set_cmd(i, 1'b0, {8'h00 | 8'(i), 24'h000100}, 32'd0);
      done_at[i] = -10;
    end
    REQ = '1;
    for (int k = 0; k < 80 && order.size() < 6; k++) begin
      step();
      if (DONE !== '0) begin
        idx = -1;
        for (int i = 0; i < NREQ; i++) if (DONE[i]) idx = i;
        checks++;
        if (!$onehot(DONE)) $display("FAIL rr_onehot: DONE=%b, required one-hot", DONE);
        else passes++;
        order.push_back(idx);
        when.push_back(cyc);
        done_at[idx] = cyc;
      end
      for (int i = 0; i < NREQ; i++) REQ[i] = (cyc != done_at[i] + 1);
    end
    checks++;
    if (order.size() != 6) $display("FAIL rr_count: %0d grants seen, required 6", order.size());
    else passes++;
    for (int i = 0; i < order.size(); i++) begin
      checks++;
      if (order[i] != exp_order[i]) $display("FAIL rr_order[%0d]: granted %0d, required %0d", i, order[i], exp_order[i]);
      else passes++;
      if (i > 0) begin
        checks++;
        if (order[i] == order[i-1] || when[i] - when[i-1] != 3)
          $display("FAIL rr_b2b[%0d]: grant %0d after %0d, gap %0d, required different and gap 3",
                   i, order[i], order[i-1], when[i] - when[i-1]);
        else passes++;
      end
    end
    REQ = '0;
    step(); step(); step();
  endtask

  task automatic test_random();
    bit [NREQ-1:0] pend;
    logic [31:0]   addr[NREQ];
    logic [31:0]   wd[NREQ];
    bit            wr[NREQ];
    int            mptr, cur, t0, guard;
    logic [31:0]   exp_rd;
    do_reset();
    mptr = 0; s_auto = 1; s_ready_en = 1;
    for (int r = 0; r < 12; r++) begin
      pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        addr[i] = {4'h0, 4'($urandom), 24'($urandom)};
        wd[i]   = $urandom;
        wr[i]   = 1'($urandom_range(0, 1));
        set_cmd(i, wr[i], addr[i], wd[i]);
      end
      REQ = pend; t0 = cyc; cur = -1; guard = 0;
      while (pend != '0 && guard < 100) begin
        step();
        guard++;
        if (PSEL !== 16'd0 && PENABLE === 1'b0) begin
          cur = -1;
          for (int k = 0; k < NREQ; k++)
            if (cur < 0 && pend[(mptr + k) % NREQ]) cur = (mptr + k) % NREQ;
          checks++;
          if (GRANT_ID !== 3'(cur) || PADDR !== addr[cur] || PWRITE !== wr[cur] ||
              PWDATA !== wd[cur] || PSEL !== (16'h0001 << addr[cur][27:24]))
            $display("FAIL rnd_grant: GID=%0d PADDR=%h PWR=%b PWDATA=%h PSEL=%h, required %0d/%h/%b/%h/%h",
                     GRANT_ID, PADDR, PWRITE, PWDATA, PSEL, cur, addr[cur], wr[cur], wd[cur],
                     16'h0001 << addr[cur][27:24]);
          else passes++;
        end
        if (DONE !== '0) begin
          checks++;
          if (cur < 0) begin
            $display("FAIL rnd_done_no_grant: DONE=%b, required a preceding SETUP", DONE);
          end else begin
            exp_rd = wr[cur] ? 32'd0 : (addr[cur] ^ 32'h5A5A_A5A5);
            if (DONE !== NREQ'(1 << cur) || RDATA !== exp_rd || RESP_ERR !== (addr[cur][3:2] == 2'b11) ||
                cyc - t0 != 3 + int'(addr[cur][1:0]))
              $display("FAIL rnd_done: DONE=%b RDATA=%h ERR=%b lat=%0d, required %b/%h/%b/%0d",
                       DONE, RDATA, RESP_ERR, cyc - t0, NREQ'(1 << cur), exp_rd,
                       addr[cur][3:2] == 2'b11, 3 + int'(addr[cur][1:0]));
            else passes++;
            pend[cur] = 1'b0;
            REQ[cur]  = 1'b0;
            mptr      = (cur + 1) % NREQ;
            t0        = cyc;
            cur       = -1;
          end
        end
      end
      checks++;
      if (pend != '0) $display("FAIL rnd_stall: round %0d pending=%b after %0d cycles, required none", r, pend, guard);
      else passes++;
      step();
    end
    s_auto = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    PRESET = 1'b1; REQ = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    test_reset();
    test_single_write();
    test_read_waits();
    test_error();
    test_timeout();
    test_midchange();
    test_reset_mid();
    test_round_robin();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
